bus_rv32_fabric: RTL and testbench



---
 rtl/bus_rv32_fabric_pkg.sv | 15 +
 rtl/bus_rv32_fabric_addr_decode.sv | 31 +++
 rtl/bus_rv32_fabric.sv | 131 +++++++++++++
 tb/tb_bus_rv32_fabric.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rv32_fabric_pkg.sv
// Shared types and default widths for the RV32 bus fabric.
//   address_width / data_width : default bus widths reused by fabric and decoder
//   bus_fabric_state_t         : transaction FSM state encoding
package bus_rv32_fabric_pkg;

  localparam int unsigned address_width = 32;
  localparam int unsigned data_width    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_fabric_state_t;

endpackage

// File: rtl/bus_rv32_fabric_addr_decode.sv
// Combinational base/mask address decoder.
//   addr : address to decode
//   hit  : at least one slave region matches
//   sel  : one-hot select; the lowest matching index wins on overlap
module bus_addr_decode
  import bus_rv32_fabric_pkg::*;
#(
  parameter int unsigned                      N_SLAVES  = 4,
  parameter int unsigned                      ADDR_W    = address_width,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0]  ADDR_MASK = '1
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [N_SLAVES-1:0] sel
);

  // Scan from the highest index down so the lowest match is written last.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i]) == BASE_ADDR[i]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rv32_fabric.sv
// Single-master bus fabric: decodes the master address onto one of N slaves,
// waits for the slave ack (bounded by TIMEOUT) and returns a one-cycle response.
//   clk_i, reset_i              : clock, synchronous active-high reset
//   m_req_i/m_we_i/m_addr_i/m_wdata_i : master request, held until m_ready_o
//   m_ready_o/m_rdata_o/m_err_o : registered one-cycle completion and response
//   s_sel_o/s_we_o/s_addr_o/s_wdata_o : registered slave request
//   s_rdata_i/s_ack_i           : per-slave read data and completion
module bus_rv32_fabric
  import bus_rv32_fabric_pkg::*;
#(
  parameter int unsigned                      N_SLAVES  = 4,
  parameter int unsigned                      ADDR_W    = address_width,
  parameter int unsigned                      DATA_W    = data_width,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0]  ADDR_MASK = '1,
  parameter int unsigned                      TIMEOUT   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         m_req_i,
  input  logic                         m_we_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  output logic                         m_ready_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_err_o,
  output logic [N_SLAVES-1:0]          s_sel_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  input  logic [N_SLAVES-1:0]          s_ack_i
);

  localparam int unsigned       TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  bus_fabric_state_t   state;
  logic [TIMER_W-1:0]  timer;
  logic                dec_hit;
  logic [N_SLAVES-1:0] dec_sel;
  logic                ack_c;
  logic [DATA_W-1:0]   sel_rdata_c;

  bus_addr_decode #(
    .N_SLAVES  (N_SLAVES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .addr (m_addr_i),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // Only the selected slave's ack counts; s_sel_o is one-hot or zero.
  assign ack_c = |(s_ack_i & s_sel_o);

  // AND-OR mux of the selected slave's read data.
  always_comb begin
    sel_rdata_c = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel_o[i]) begin
        sel_rdata_c = sel_rdata_c | s_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered slave request and master response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      timer     <= '0;
      m_ready_o <= 1'b0;
      m_err_o   <= 1'b0;
      m_rdata_o <= '0;
      s_sel_o   <= '0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
    end else begin
      m_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req_i) begin
            if (dec_hit) begin
              s_sel_o   <= dec_sel;
              s_we_o    <= m_we_i;
              s_addr_o  <= m_addr_i;
              s_wdata_o <= m_wdata_i;
              timer     <= '0;
              state     <= ACCESS;
            end else begin
              m_err_o   <= 1'b1;
              m_rdata_o <= '0;
              m_ready_o <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (ack_c) begin
            m_rdata_o <= s_we_o ? '0 : sel_rdata_c;
            m_err_o   <= 1'b0;
            m_ready_o <= 1'b1;
            s_sel_o   <= '0;
            s_we_o    <= 1'b0;
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            m_rdata_o <= '0;
            m_err_o   <= 1'b1;
            m_ready_o <= 1'b1;
            s_sel_o   <= '0;
            s_we_o    <= 1'b0;
            state     <= RESP;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rv32_fabric.sv
// Randomized scoreboard bench for bus_rv32_fabric (4 slaves, 32-bit, TIMEOUT=16).
module tb_bus_rv32_fabric;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam int NEVER = 1000;
  localparam logic [NS-1:0][31:0] BASE = {32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] MASK = {32'hFFFF_FFC0, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};

  logic           clk = 1'b0;
  logic           reset_i;
  logic           m_req_i, m_we_i;
  logic [31:0]    m_addr_i, m_wdata_i;
  logic           m_ready_o, m_err_o, s_we_o;
  logic [31:0]    m_rdata_o, s_addr_o, s_wdata_o;
  logic [NS-1:0]  s_sel_o, s_ack_i;
  logic [NS*32-1:0] s_rdata_i;

  bus_rv32_fabric #(
    .N_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
    .BASE_ADDR(BASE), .ADDR_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, err;
    int          idx, lat, selc, issue;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        me;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          sel_cnt = 0;
  int          plan_idx = -1, plan_wait = 0;
  logic [31:0] plan_data = '0;
  int          acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  // Reference decode: first slave index whose masked address equals its base.
  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  // Slave responder: acks the planned slave after plan_wait wait cycles,
  // sprinkles random acks on every other slave and randomizes all read data.
  always @(negedge clk) begin
    logic [NS-1:0] ack, keep;
    ack  = '0;
    keep = '1;
    for (int i = 0; i < NS; i++) s_rdata_i[i*32 +: 32] = $urandom;
    if (plan_idx >= 0) keep[plan_idx] = 1'b0;
    if (s_sel_o != '0 && plan_idx >= 0) begin
      if (acc_cnt == plan_wait) begin
        ack[plan_idx] = 1'b1;
        s_rdata_i[plan_idx*32 +: 32] = plan_data;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
    s_ack_i = ack | (NS'($urandom) & keep);
  end

  // Monitor: checks the slave-side request while selected, and pops one
  // expected response per m_ready_o.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (s_sel_o != '0) begin
        if (sb_q.size() == 0) begin
          chk("sel_without_request", 32'(s_sel_o), 32'd0);
        end else begin
          me = sb_q[0];
          sel_cnt++;
          chk("s_sel", 32'(s_sel_o), (me.idx < 0) ? 32'd0 : 32'(1 << me.idx));
          chk("s_addr", s_addr_o, me.addr);
          chk("s_we", 32'(s_we_o), 32'(me.we));
          chk("s_wdata", s_wdata_o, me.wdata);
        end
      end
      if (m_ready_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 32'(m_ready_o), 32'd0);
        end else begin
          me = sb_q.pop_front();
          chk("m_rdata", m_rdata_o, me.rdata);
          chk("m_err", 32'(m_err_o), 32'(me.err));
          chk("ready_latency", 32'(cyc - me.issue), 32'(me.lat));
          chk("sel_cycles", 32'(sel_cnt), 32'(me.selc));
          sel_cnt = 0;
        end
      end
    end
  end

  // Issue one transaction (called just after a negedge, DUT in IDLE) and wait for m_ready_o.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int wt, input logic [31:0] rd, input bit b2b);
    exp_t e;
    int   budget;
    e.idx = model_decode(a);
    e.addr = a; e.we = w; e.wdata = wd;
    if (e.idx < 0) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.selc = 0;
    end else if (wt <= TO - 1) begin
      e.err = 1'b0; e.rdata = w ? 32'd0 : rd; e.lat = wt + 2; e.selc = wt + 1;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.lat = TO + 1; e.selc = TO;
    end
    e.issue   = cyc;
    plan_idx  = e.idx;
    plan_wait = wt;
    plan_data = rd;
    sb_q.push_back(e);
    m_req_i = 1'b1; m_we_i = w; m_addr_i = a; m_wdata_i = wd;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!m_ready_o && budget < 64);
    if (!m_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: no m_ready_o within %0d cycles for addr 0x%08h", budget, a);
      m_req_i = 1'b0;
      reset_i = 1'b1;
      @(posedge clk); #1;
      sb_q.delete(); sel_cnt = 0;
      @(negedge clk);
      reset_i = 1'b0;
    end else begin
      if (!b2b) m_req_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_m_ready"}, 32'(m_ready_o), 32'd0);
    chk({tag, "_m_err"},   32'(m_err_o),   32'd0);
    chk({tag, "_m_rdata"}, m_rdata_o,      32'd0);
    chk({tag, "_s_sel"},   32'(s_sel_o),   32'd0);
    chk({tag, "_s_we"},    32'(s_we_o),    32'd0);
    chk({tag, "_s_addr"},  s_addr_o,       32'd0);
    chk({tag, "_s_wdata"}, s_wdata_o,      32'd0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a;
    int          wt, kind;
    reset_i = 1'b1; m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_wdata_i = '0;
    s_ack_i = '0; s_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_i = 1'b0;

    // Directed cases
    run_txn(32'h0000_1004, 1'b0, 32'h1111_2222, 0,     32'hDEAD_BEEF, 1'b0);
    run_txn(32'h0000_2008, 1'b1, 32'h0000_0055, 3,     32'hCAFE_F00D, 1'b0);
    run_txn(32'h0000_F000, 1'b0, 32'h0,         0,     32'h1234_5678, 1'b0);
    run_txn(32'h0000_1000, 1'b0, 32'h0,         NEVER, 32'h0BAD_0BAD, 1'b0);
    run_txn(32'h0000_1010, 1'b0, 32'h0,         TO-1,  32'hA5A5_5A5A, 1'b1);
    run_txn(32'h0000_0010, 1'b0, 32'h0,         1,     32'h0F0F_00F0, 1'b1);
    run_txn(32'h0000_203C, 1'b1, 32'h7777_8888, 0,     32'h0,         1'b0);

    // Reset pulsed during ACCESS aborts the transaction with no response
    e.idx = 1; e.addr = 32'h0000_1100; e.we = 1'b1; e.wdata = 32'h0000_00AA;
    e.rdata = '0; e.err = 1'b0; e.lat = 0; e.selc = 0; e.issue = cyc;
    plan_idx = 1; plan_wait = NEVER; plan_data = '0;
    sb_q.push_back(e);
    m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = e.addr; m_wdata_i = e.wdata;
    repeat (4) @(negedge clk);
    reset_i = 1'b1; m_req_i = 1'b0;
    @(posedge clk); #1;
    sb_q.delete(); sel_cnt = 0;
    @(negedge clk);
    reset_i = 1'b0;
    check_zero_outputs("abort");
    repeat (3) @(negedge clk);
    run_txn(32'h0000_2000, 1'b0, 32'h0, 2, 32'h600D_CAFE, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = 32'($urandom_range(0, 255));
        1:       a = 32'h0000_1000 | (32'($urandom) & 32'h0000_0FFF);
        2:       a = 32'h0000_2000 | (32'($urandom) & 32'h0000_0FFF);
        default: a = 32'h0001_0000 | 32'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       wt = NEVER;
        1:       wt = TO - 1;
        default: wt = $urandom_range(0, 4);
      endcase
      run_txn(a, 1'($urandom), 32'($urandom), wt, 32'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        m_req_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    m_req_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
